// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Frame errors and FIFO overflows are reported as single-cycle pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              i_serial_rx,
  output logic [7:0]                        o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_frame_err,
  output logic                              o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_meta;
  logic             rxs;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_serial_rx;
      rxs     <= rx_meta;
    end
  end

  // Every bit-period decision is taken on the cycle the down-counter sits at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            bit_cnt <= HALF_BIT;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            bit_cnt <= FULL_BIT;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            o_frame_err <= 1'b1;
            state       <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The byte is written on the stop-sample edge itself so it is visible next cycle.
  assign push    = (state == STOP) && (bit_cnt == '0) && rxs;
  assign o_valid = (o_count != '0);
  assign pop     = o_valid && i_ready;
  assign full    = (o_count == FULL_OCC);
  assign wr_en   = push && (!full || pop);
  assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of single frames plus
// hand-written sequences for glitches, line breaks, overflow, full+pop and reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_serial_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic [3:0] o_count;
  logic       o_frame_err;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;
  logic [7:0] popped [$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_pops;
    int         exp_errs;
  } vec_t;

  vec_t vecs [7];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_serial_rx (i_serial_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  // Consumer-side observer: records every accepted byte and every event pulse.
  always @(negedge clk) begin
    if (o_valid && i_ready) popped.push_back(o_data);
    if (o_frame_err) err_pulses++;
    if (o_overflow)  ovf_pulses++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_monitor();
    popped.delete();
    err_pulses = 0;
    ovf_pulses = 0;
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < popped.size()) return {24'h0, popped[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    i_serial_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      i_serial_rx = data[i];
      wait_cycles(CPB);
    end
    i_serial_rx = stop_bit;
    wait_cycles(CPB);
    i_serial_rx = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clear_monitor();
    i_ready = 1'b1;
    send_byte(v.data, v.stop_bit);
    wait_cycles(8);
    checkOutput("vec_pops",   popped.size(), v.exp_pops);
    checkOutput("vec_data",   (v.exp_pops > 0) ? pop_at(0) : 32'hFFFF_FFFF,
                              (v.exp_pops > 0) ? {24'h0, v.data} : 32'hFFFF_FFFF);
    checkOutput("vec_errs",   err_pulses, v.exp_errs);
    checkOutput("vec_ovf",    ovf_pulses, 0);
    checkOutput("vec_count",  o_count, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h11, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 0};

    rstn        = 1'b0;
    i_serial_rx = 1'b1;
    i_ready     = 1'b0;
    wait_cycles(3);
    checkOutput("rst_count", o_count, 0);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_data",  o_data, 0);
    checkOutput("rst_ferr",  o_frame_err, 0);
    checkOutput("rst_ovf",   o_overflow, 0);
    rstn = 1'b1;
    wait_cycles(4);

    for (int v = 0; v < 7; v++) applyStimulus(vecs[v]);

    // Short low pulse must be rejected as a false start.
    clear_monitor();
    i_ready = 1'b1;
    i_serial_rx = 1'b0;
    wait_cycles(4);
    i_serial_rx = 1'b1;
    wait_cycles(3 * CPB);
    checkOutput("glitch_pops",  popped.size(), 0);
    checkOutput("glitch_count", o_count, 0);
    checkOutput("glitch_errs",  err_pulses, 0);

    // Framing error followed by a long break, then a clean frame.
    clear_monitor();
    send_byte(8'h3C, 1'b0);
    i_serial_rx = 1'b0;
    wait_cycles(40 * CPB);
    i_serial_rx = 1'b1;
    wait_cycles(2 * CPB);
    checkOutput("break_errs", err_pulses, 1);
    checkOutput("break_pops", popped.size(), 0);
    clear_monitor();
    send_byte(8'h11, 1'b1);
    wait_cycles(8);
    checkOutput("after_break_pops", popped.size(), 1);
    checkOutput("after_break_data", pop_at(0), 32'h11);
    checkOutput("after_break_errs", err_pulses, 0);

    // Ten bytes into an eight-deep FIFO with no consumer.
    clear_monitor();
    i_ready = 1'b0;
    for (int b = 0; b < 10; b++) begin
      send_byte(8'(b), 1'b1);
      wait_cycles(4);
    end
    checkOutput("ovf_count", o_count, 8);
    checkOutput("ovf_pulses", ovf_pulses, 2);
    checkOutput("ovf_valid", o_valid, 1);
    checkOutput("ovf_head", o_data, 8'h00);
    i_ready = 1'b1;
    wait_cycles(12);
    i_ready = 1'b0;
    checkOutput("ovf_drain_n", popped.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("ovf_drain_data", pop_at(i), i);
    checkOutput("ovf_drain_count", o_count, 0);

    // Full FIFO, consumer accepts exactly on the stop-sample cycle of a 9th byte.
    clear_monitor();
    for (int b = 0; b < 8; b++) begin
      send_byte(8'h10 + 8'(b), 1'b1);
      wait_cycles(4);
    end
    checkOutput("full_count", o_count, 8);
    clear_monitor();
    fork
      send_byte(8'h18, 1'b1);
      begin
        wait_cycles(154);
        i_ready = 1'b1;
        wait_cycles(1);
        i_ready = 1'b0;
      end
    join
    wait_cycles(4);
    checkOutput("fullpop_ovf",   ovf_pulses, 0);
    checkOutput("fullpop_count", o_count, 8);
    checkOutput("fullpop_n",     popped.size(), 1);
    checkOutput("fullpop_first", pop_at(0), 32'h10);
    checkOutput("fullpop_head",  o_data, 8'h11);
    clear_monitor();
    i_ready = 1'b1;
    wait_cycles(12);
    i_ready = 1'b0;
    checkOutput("fullpop_drain_n", popped.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("fullpop_drain_data", pop_at(i), 32'h11 + i);

    // Reset in the middle of data bit 4 of 0xFF, then a fresh frame.
    clear_monitor();
    i_serial_rx = 1'b0;
    wait_cycles(CPB);
    i_serial_rx = 1'b1;
    wait_cycles(4 * CPB + 8);
    rstn = 1'b0;
    #2;
    checkOutput("midrst_count", o_count, 0);
    checkOutput("midrst_valid", o_valid, 0);
    checkOutput("midrst_data",  o_data, 0);
    wait_cycles(4);
    rstn = 1'b1;
    wait_cycles(20 * CPB);
    checkOutput("midrst_nopush", o_count, 0);
    send_byte(8'h42, 1'b1);
    wait_cycles(4);
    checkOutput("midrst_new_count", o_count, 1);
    checkOutput("midrst_new_data",  o_data, 8'h42);
    checkOutput("midrst_errs",      err_pulses, 0);
    i_ready = 1'b1;
    wait_cycles(4);
    i_ready = 1'b0;
    checkOutput("midrst_pops", popped.size(), 1);
    checkOutput("midrst_pop0", pop_at(0), 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
